pe_reduce: RTL

- Reverse-direction companion to the CU→PE broadcast path. Collects one 16-bit value and one enable bit from every PE in the same cycle, reduces them through a pipelined OR tree, and returns a single word plus flags to the CU.
- Serves `OPgor` (global OR, result written back to the destination register) and `OPjumpf` (CU jump decision across all enabled PEs).
- Sits between the PE array and the CU fetch stage; fully pipelined at one request per cycle.

---
 rtl/pe_reduce_pkg.sv | 40 ++++
 rtl/pe_reduce_level.sv | 57 +++++
 rtl/pe_reduce.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pe_reduce_pkg.sv
// Shared widths, opcodes and tree-shape helpers for the PE-to-CU OR reduction.
// Opcode values match the processor's decode so decode, PE and reducer agree.
package pe_reduce_pkg;

   localparam int WORD    = 16;
   localparam int REGNAME = 4;
   localparam int OP      = 5;

   localparam logic [OP-1:0] OP_NOP   = 5'b00000;
   localparam logic [OP-1:0] OP_ADD   = 5'b00001;
   localparam logic [OP-1:0] OP_JUMPF = 5'b01110;
   localparam logic [OP-1:0] OP_GOR   = 5'b10101;

   // Number of surviving lanes after lvl pairwise-OR levels starting from n lanes.
   function automatic int lane_count(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) begin
         c = (c + 1) / 2;
      end
      return c;
   endfunction

   function automatic int tree_levels(input int n);
      int c;
      int l;
      c = n;
      l = 0;
      while (c > 1) begin
         c = (c + 1) / 2;
         l = l + 1;
      end
      return l;
   endfunction

   function automatic logic op_accepted(input logic [OP-1:0] op);
      return (op == OP_GOR) || (op == OP_JUMPF);
   endfunction

endpackage

// File: rtl/pe_reduce_level.sv
// One registered level of the OR tree: pairs of lanes are ORed, an odd last lane
// passes through, and op/tag/valid travel alongside. Everything freezes on hold.
module reduce_level
   import pe_reduce_pkg::*;
#(
   parameter int NIN = 2,
   localparam int NOUT = (NIN + 1) / 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                hold,
   input  logic                src_valid,
   input  logic [WORD*NIN-1:0] src_vals,
   input  logic [NIN-1:0]      src_en,
   input  logic [OP-1:0]       src_op,
   input  logic [REGNAME-1:0]  src_dst,
   output logic                red_valid,
   output logic [WORD*NOUT-1:0] red_vals,
   output logic [NOUT-1:0]     red_en,
   output logic [OP-1:0]       red_op,
   output logic [REGNAME-1:0]  red_dst
);

   logic [WORD*NOUT-1:0] pair_vals;
   logic [NOUT-1:0]      pair_en;

   for (genvar j = 0; j < NOUT; j++) begin : lane
      if (2*j + 1 < NIN) begin : merge
         assign pair_vals[WORD*j +: WORD] = src_vals[WORD*(2*j) +: WORD] | src_vals[WORD*(2*j+1) +: WORD];
         assign pair_en[j]                = src_en[2*j] | src_en[2*j+1];
      end else begin : carry
         assign pair_vals[WORD*j +: WORD] = src_vals[WORD*(2*j) +: WORD];
         assign pair_en[j]                = src_en[2*j];
      end
   end

   // Data only reloads with a valid request so the final level holds its last result;
   // enables reset high so the derived "no PE enabled" flag reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         red_valid <= 1'b0;
         red_vals  <= '0;
         red_en    <= '1;
         red_op    <= '0;
         red_dst   <= '0;
      end else if (!hold) begin
         red_valid <= src_valid;
         if (src_valid) begin
            red_vals <= pair_vals;
            red_en   <= pair_en;
            red_op   <= src_op;
            red_dst  <= src_dst;
         end
      end
   end

endmodule

// File: rtl/pe_reduce.sv
// PE-to-CU global OR reducer: masks each PE value by its enable, ORs them through a
// pipelined tree and returns the word plus flags for OPgor / OPjumpf.
module pe_reduce
   import pe_reduce_pkg::*;
#(
   parameter int NPROC = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  req,
   input  logic [OP-1:0]         reqop,
   input  logic [REGNAME-1:0]    reqdst,
   input  logic [WORD*NPROC-1:0] pevals,
   input  logic [NPROC-1:0]      peen,
   output logic                  done,
   output logic [OP-1:0]         doneop,
   output logic [REGNAME-1:0]    donedst,
   output logic [WORD-1:0]       result,
   output logic                  anytrue,
   output logic                  noneen,
   output logic                  jumptaken,
   output logic                  busy
);

   localparam int LVLS = tree_levels(NPROC);

   logic                  accept;
   logic [WORD*NPROC-1:0] masked;

   logic                  s0_valid;
   logic [WORD*NPROC-1:0] s0_vals;
   logic [NPROC-1:0]      s0_en;
   logic [OP-1:0]         s0_op;
   logic [REGNAME-1:0]    s0_dst;

   logic [LVLS:0]         stage_valid;

   logic                  fin_valid;
   logic [WORD-1:0]       fin_vals;
   logic                  fin_en;
   logic [OP-1:0]         fin_op;
   logic [REGNAME-1:0]    fin_dst;

   assign accept = req & op_accepted(reqop);

   for (genvar i = 0; i < NPROC; i++) begin : mask
      assign masked[WORD*i +: WORD] = peen[i] ? pevals[WORD*i +: WORD] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid <= 1'b0;
         s0_vals  <= '0;
         s0_en    <= '1;
         s0_op    <= '0;
         s0_dst   <= '0;
      end else if (!hold) begin
         s0_valid <= accept;
         if (accept) begin
            s0_vals <= masked;
            s0_en   <= peen;
            s0_op   <= reqop;
            s0_dst  <= reqdst;
         end
      end
   end

   assign stage_valid[0] = s0_valid;

   // Each level owns exactly-sized outputs; the next level reaches back into the previous block.
   for (genvar g = 0; g < LVLS; g++) begin : lvl
      localparam int NIN  = lane_count(NPROC, g);
      localparam int NOUT = lane_count(NPROC, g + 1);

      logic                valid;
      logic [WORD*NOUT-1:0] vals;
      logic [NOUT-1:0]     en;
      logic [OP-1:0]       op;
      logic [REGNAME-1:0]  dst;

      if (g == 0) begin : head
         reduce_level #(.NIN(NIN)) u_level (
            .clk       (clk),
            .reset     (reset),
            .hold      (hold),
            .src_valid (s0_valid),
            .src_vals  (s0_vals),
            .src_en    (s0_en),
            .src_op    (s0_op),
            .src_dst   (s0_dst),
            .red_valid (valid),
            .red_vals  (vals),
            .red_en    (en),
            .red_op    (op),
            .red_dst   (dst)
         );
      end else begin : link
         reduce_level #(.NIN(NIN)) u_level (
            .clk       (clk),
            .reset     (reset),
            .hold      (hold),
            .src_valid (lvl[g-1].valid),
            .src_vals  (lvl[g-1].vals),
            .src_en    (lvl[g-1].en),
            .src_op    (lvl[g-1].op),
            .src_dst   (lvl[g-1].dst),
            .red_valid (valid),
            .red_vals  (vals),
            .red_en    (en),
            .red_op    (op),
            .red_dst   (dst)
         );
      end

      assign stage_valid[g+1] = valid;
   end

   if (LVLS == 0) begin : direct
      assign fin_valid = s0_valid;
      assign fin_vals  = s0_vals;
      assign fin_en    = s0_en[0];
      assign fin_op    = s0_op;
      assign fin_dst   = s0_dst;
   end else begin : tail
      assign fin_valid = lvl[LVLS-1].valid;
      assign fin_vals  = lvl[LVLS-1].vals;
      assign fin_en    = lvl[LVLS-1].en[0];
      assign fin_op    = lvl[LVLS-1].op;
      assign fin_dst   = lvl[LVLS-1].dst;
   end

   // Outputs are decoded only from the last registered level, never from the inputs.
   assign done      = fin_valid;
   assign doneop    = fin_op;
   assign donedst   = fin_dst;
   assign result    = fin_vals;
   assign anytrue   = |fin_vals;
   assign noneen    = ~fin_en;
   assign jumptaken = fin_valid & (fin_op == OP_JUMPF) & ~(|fin_vals);
   assign busy      = |stage_valid;

endmodule
